// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: AES SubBytes / InvSubBytes over an NBYTES-byte block.
// LANES bytes are substituted per cycle, so a block takes BEATS = NBYTES/LANES
// cycles in RUN. Each lane computes the S-box arithmetically: a GF(2^8)
// inverse (as x^254) combined with the FIPS-197 affine transform or its inverse.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds in_valid until it sees in_ready. The block holds
// out_valid and state_out stable until it sees out_ready.
module sub_bytes_seq #(
    parameter int NBYTES = 16,
    parameter int LANES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [8*NBYTES-1:0]   state_in,
    output logic [8*NBYTES-1:0]   state_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int BEATS = NBYTES / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    // A block must split into whole beats.
    if ((NBYTES % LANES) != 0) begin : g_bad_cfg
        $error("sub_bytes_seq: NBYTES must be a multiple of LANES");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                            state;
    logic [BEATS-1:0][LANES-1:0][7:0]  work;
    logic [BEATS-1:0][LANES-1:0][7:0]  work_upd;
    logic [BW-1:0]                     beat;
    logic                              mode_r;
    logic [LANES-1:0][7:0]             lane_in;
    logic [LANES-1:0][7:0]             lane_out;

    // GF(2^8) product modulo x^8+x^4+x^3+x+1 (shift-and-add).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^(2+4+...+128); maps 0 to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Forward affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    // Substitution lanes; mode_r was captured with the block, not the live input.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_out[j] = mode_r ? gf_inv(inv_affine(lane_in[j]))
                                    : fwd_affine(gf_inv(lane_in[j]));
    end

    // Route the current beat's bytes through the lanes and back into place.
    if (BEATS == 1) begin : g_one_beat
        assign lane_in  = work[0];
        assign work_upd = lane_out;
    end else begin : g_multi_beat
        assign lane_in = work[beat];
        // Working register with the current beat's bytes replaced.
        always_comb begin
            work_upd       = work;
            work_upd[beat] = lane_out;
        end
    end

    assign state_out = work;

    // Control FSM with registered handshake/status outputs and the working register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            beat      <= '0;
            mode_r    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= state_in;
                        mode_r   <= mode;
                        beat     <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    work <= work_upd;
                    if (beat == LAST_BEAT) begin
                        beat      <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: fixed vectors, handshake/reset corner cases,
// random blocks against a table-based S-box model, and a full 256-byte
// round trip on four lane widths.
module tb_sub_bytes_seq;
  localparam int NB = 16;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst;
  logic mode;
  logic [8*NB-1:0] state_in;
  logic in_valid_v [NI];
  logic out_ready_v [NI];
  logic in_ready_v [NI];
  logic out_valid_v [NI];
  logic busy_v [NI];
  logic [8*NB-1:0] state_out_v [NI];

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox [256];
  logic [7:0] inv_sbox [256];
  logic [8*NB-1:0] exp_q[$];

  typedef struct {
    logic [8*NB-1:0] din;
    logic            m;
    logic [8*NB-1:0] dout;
  } vec_t;
  vec_t vecs [6];

  // clock / reset block
  always #5 clk = ~clk;

  // instance 0: LANES=4 (main), 1: LANES=1, 2: LANES=2, 3: LANES=16
  for (genvar g = 0; g < NI; g++) begin : g_dut
    sub_bytes_seq #(
      .NBYTES(NB),
      .LANES (g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 2 : 16)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid_v[g]),
      .in_ready (in_ready_v[g]),
      .mode     (mode),
      .state_in (state_in),
      .state_out(state_out_v[g]),
      .out_valid(out_valid_v[g]),
      .out_ready(out_ready_v[g]),
      .busy     (busy_v[g])
    );
  end

  function automatic int beats_of(input int k);
    int lanes;
    lanes = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : 16;
    return NB / lanes;
  endfunction

  // reference model: polynomial product then reduction by 0x11b
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    logic [15:0] poly;
    prod = 16'h0000;
    poly = 16'h011b;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (prod[i]) prod = prod ^ (poly << (i - 8));
    return prod[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
             ^ inv[(i + 7) % 8] ^ c[i];
      sbox[x] = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [8*NB-1:0] model_block(input logic [8*NB-1:0] din, input logic m);
    logic [8*NB-1:0] r;
    for (int i = 0; i < NB; i++)
      r[8*i +: 8] = m ? inv_sbox[din[8*i +: 8]] : sbox[din[8*i +: 8]];
    return r;
  endfunction

  // scoreboard compare
  task automatic chk(input string nm, input logic [8*NB-1:0] act, input logic [8*NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on the DUT", nm);
  endtask

  // driver: send one block to instance k, return result and latency in cycles
  task automatic run_block(input int k, input logic [8*NB-1:0] din, input logic m,
                           output logic [8*NB-1:0] dout, output int lat);
    int n;
    @(negedge clk);
    state_in = din;
    mode = m;
    in_valid_v[k] = 1'b1;
    n = 0;
    while (!in_ready_v[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_v[k]) fail_now("accept");
    @(posedge clk);
    #1;
    in_valid_v[k] = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    mode = ~m;
    lat = 0;
    while (!out_valid_v[k] && lat < 100) begin
      chk("busy_in_run", 128'(busy_v[k]), 128'(1));
      chk("in_ready_in_run", 128'(in_ready_v[k]), 128'(0));
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid_v[k]) fail_now("out_valid");
    chk("busy_in_done", 128'(busy_v[k]), 128'(0));
    dout = state_out_v[k];
    out_ready_v[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[k] = 1'b0;
    chk("out_valid_release", 128'(out_valid_v[k]), 128'(0));
  endtask

  initial begin
    logic [8*NB-1:0] dout;
    logic [8*NB-1:0] fo;
    logic [8*NB-1:0] din;
    logic [8*NB-1:0] exp;
    logic m;
    int lat;
    int n;

    vecs[0] = '{128'h0848f8e92a8dc69a2be2f4a0bee33d19, 1'b0, 128'h3052411ee55db4b8f198bfe0ae1127d4};
    vecs[1] = '{128'h3052411ee55db4b8f198bfe0ae1127d4, 1'b1, 128'h0848f8e92a8dc69a2be2f4a0bee33d19};
    vecs[2] = '{128'h0, 1'b0, {16{8'h63}}};
    vecs[3] = '{128'h0, 1'b1, {16{8'h52}}};
    vecs[4] = '{128'h53, 1'b0, 128'h636363636363636363636363636363ed};
    vecs[5] = '{128'hed, 1'b1, 128'h52525252525252525252525252525253};

    build_tables();

    rst = 1'b1;
    mode = 1'b0;
    state_in = '0;
    for (int k = 0; k < NI; k++) begin
      in_valid_v[k] = 1'b0;
      out_ready_v[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset_out_valid%0d", k), 128'(out_valid_v[k]), 128'(0));
      chk($sformatf("reset_state_out%0d", k), state_out_v[k], 128'(0));
      chk($sformatf("reset_busy%0d", k), 128'(busy_v[k]), 128'(0));
      chk($sformatf("reset_in_ready%0d", k), 128'(in_ready_v[k]), 128'(1));
    end

    // table-driven vectors on the main instance
    for (int i = 0; i < 6; i++) begin
      run_block(0, vecs[i].din, vecs[i].m, dout, lat);
      chk($sformatf("vec%0d_data", i), dout, vecs[i].dout);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(4));
    end

    // DONE hold with out_ready low, in_valid ignored, early out_ready ignored
    @(negedge clk);
    state_in = vecs[0].din;
    mode = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[0] = 1'b0;
    chk("early_ready_busy", 128'(busy_v[0]), 128'(1));
    chk("early_ready_out_valid", 128'(out_valid_v[0]), 128'(0));
    n = 0;
    while (!out_valid_v[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid_v[0]) fail_now("hold_out_valid");
    chk("hold_latency", 128'(n + 1), 128'(4));
    state_in = vecs[2].din;
    mode = 1'b1;
    in_valid_v[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold_out_valid", 128'(out_valid_v[0]), 128'(1));
      chk("hold_state_out", state_out_v[0], vecs[0].dout);
      chk("hold_in_ready", 128'(in_ready_v[0]), 128'(0));
    end
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[0] = 1'b0;
    chk("release_out_valid", 128'(out_valid_v[0]), 128'(0));
    chk("release_in_ready", 128'(in_ready_v[0]), 128'(1));
    @(posedge clk);
    #1;
    chk("release_no_restart", 128'(busy_v[0]), 128'(0));

    // reset at beat 2 discards the block
    @(negedge clk);
    state_in = vecs[0].din;
    mode = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", 128'(out_valid_v[0]), 128'(0));
    chk("midrst_state_out", state_out_v[0], 128'(0));
    chk("midrst_in_ready", 128'(in_ready_v[0]), 128'(1));
    chk("midrst_busy", 128'(busy_v[0]), 128'(0));
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_pulse", 128'(out_valid_v[0]), 128'(0));
    end

    // reset wins over a handshake on the same edge
    state_in = vecs[0].din;
    in_valid_v[0] = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid_v[0] = 1'b0;
    chk("rst_prio_busy", 128'(busy_v[0]), 128'(0));
    chk("rst_prio_state_out", state_out_v[0], 128'(0));
    chk("rst_prio_in_ready", 128'(in_ready_v[0]), 128'(1));

    run_block(0, vecs[4].din, vecs[4].m, dout, lat);
    chk("after_rst_data", dout, vecs[4].dout);
    chk("after_rst_latency", 128'(lat), 128'(4));

    // random blocks against the model
    for (int i = 0; i < 40; i++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      exp_q.push_back(model_block(din, m));
      run_block(0, din, m, dout, lat);
      exp = exp_q.pop_front();
      chk($sformatf("rand%0d_data", i), dout, exp);
      chk($sformatf("rand%0d_latency", i), 128'(lat), 128'(4));
    end

    // all 256 byte values forward then inverse on each lane width
    for (int k = 0; k < NI; k++) begin
      for (int b = 0; b < 16; b++) begin
        for (int i = 0; i < NB; i++) din[8*i +: 8] = 8'(b * 16 + i);
        run_block(k, din, 1'b0, fo, lat);
        chk($sformatf("sweep%0d_blk%0d_fwd", k, b), fo, model_block(din, 1'b0));
        chk($sformatf("sweep%0d_blk%0d_fwd_lat", k, b), 128'(lat), 128'(beats_of(k)));
        run_block(k, fo, 1'b1, dout, lat);
        chk($sformatf("sweep%0d_blk%0d_roundtrip", k, b), dout, din);
        chk($sformatf("sweep%0d_blk%0d_inv_lat", k, b), 128'(lat), 128'(beats_of(k)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard time limit in case the run stops making progress
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sub_bytes_seq.md
SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 The block SHALL have parameter NBYTES, default 16: number of state bytes per block.
REQ-002 The block SHALL have parameter LANES, default 4: bytes substituted per cycle. NBYTES mod LANES != 0 SHALL cause an elaboration error. BEATS = NBYTES/LANES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input block is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept input.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 selects forward S-box, 1 selects inverse S-box; sampled with the input block.
REQ-008 The block SHALL have port state_in, input, 8*NBYTES bits: byte i occupies bits [8i+7:8i].
REQ-009 The block SHALL have port state_out, output, 8*NBYTES bits: substituted block, same byte order as state_in.
REQ-010 The block SHALL have port out_valid, output, 1 bit: state_out holds a complete result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port busy, output, 1 bit: high in the RUN state.

Function
REQ-013 Each lane SHALL compute the forward S-box as the multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1, with 0 mapping to 0, followed by the FIPS-197 affine transform (constant 0x63).
REQ-014 Each lane SHALL compute the inverse S-box as the inverse affine transform (constant 0x05) followed by the GF(2^8) inverse. Lanes SHALL NOT use 256-entry case tables.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, an edge where in_valid and in_ready are both 1 SHALL latch state_in and mode, clear the beat counter, and move the FSM to RUN.
REQ-018 Changes to mode or state_in after acceptance SHALL have no effect on the block in flight.
REQ-019 In RUN, beat k (k = 0..BEATS-1, one per cycle, ascending) SHALL substitute bytes k*LANES .. k*LANES+LANES-1 in place; the beat counter SHALL wrap to 0 after BEATS-1.
REQ-020 On the edge that completes beat BEATS-1, the FSM SHALL enter DONE and out_valid SHALL become 1.
REQ-021 Latency: acceptance at edge t SHALL give out_valid=1 after edge t+BEATS (for example t+4 at default parameters). The LANES=NBYTES case SHALL give a latency of 1.
REQ-022 In DONE, out_valid and state_out SHALL stay stable until an edge with out_ready=1; that edge SHALL move the FSM to IDLE and set out_valid to 0.
REQ-023 Sustained throughput SHALL be one block per BEATS+2 cycles.
REQ-024 in_valid asserted outside IDLE SHALL be ignored. The upstream source holds in_valid until in_ready is seen.
REQ-025 state_out SHALL show the partially substituted working register during RUN; the consumer SHALL use it only while out_valid=1.
REQ-026 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-027 With rst=1 at an edge, the FSM SHALL go to IDLE, and state_out, the beat counter, out_valid and busy SHALL all be 0.
REQ-028 With rst=1 at an edge, in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-029 A reset during RUN or DONE SHALL discard the block in flight; no out_valid pulse SHALL follow.
REQ-030 rst SHALL take priority over every handshake on the same edge.

Verification
REQ-031 The bench SHALL cover: mode=0, state_in bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 -> state_out = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30, with out_valid 4 cycles after acceptance.
REQ-032 The bench SHALL cover: mode=1 with the output of REQ-031 as input -> the original REQ-031 input is returned.
REQ-033 The bench SHALL cover: all-zero input -> mode=0 gives all 0x63; mode=1 gives all 0x52. Also byte 0x53 forward -> 0xED.
REQ-034 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, state_out is unchanged and in_ready stays 0; out_ready=1 -> IDLE on the next edge.
REQ-035 The bench SHALL cover: rst pulsed at beat 2 -> out_valid stays 0, state_out = 0 and in_ready = 1 after the reset; a new block is then processed correctly.
REQ-036 The bench SHALL cover: for each LANES in {1, 2, 4, 16}, all 256 byte values sent forward then inverse -> the input is returned exactly, with latency equal to BEATS.
